sw_debounce: RTL and testbench

SW_DEBOUNCE -- requirements
Module: sw_debounce

---
 rtl/sw_debounce_pkg.sv | 13 +
 rtl/sw_debounce_sync.sv | 21 ++
 rtl/sw_debounce.sv | 98 +++++++++
 tb/tb_sw_debounce.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/sw_debounce_pkg.sv
// Shared types and defaults for the switch debouncer.
package sw_debounce_pkg;

    typedef enum logic [1:0] {
        LO      = 2'd0,
        WAIT_HI = 2'd1,
        HI      = 2'd2,
        WAIT_LO = 2'd3
    } debState_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/sw_debounce_sync.sv
// Two-flop synchronizer that brings the raw switch level into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sw_debounce.sv
// Switch debouncer: four-state FSM accepts a level after DEBOUNCE_CYCLES stable samples.
// Define SW_DEBOUNCE_SYNC_EN to put a two-flop synchronizer in front of the FSM.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_raw,
    output logic sw_clean,
    output logic sw_rise,
    output logic sw_fall
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s;
    debState_t     state;
    logic [CW-1:0] count;

`ifdef SW_DEBOUNCE_SYNC_EN
    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sw_raw),
        .q     (s)
    );
`else
    assign s = sw_raw;
`endif

    // sw_clean is updated on the same edge that moves state, so it always
    // equals (state == HI || state == WAIT_LO).
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= LO;
            count    <= '0;
            sw_clean <= 1'b0;
            sw_rise  <= 1'b0;
            sw_fall  <= 1'b0;
        end else begin
            sw_rise <= 1'b0;
            sw_fall <= 1'b0;
            case (state)
                LO: begin
                    if (s) begin
                        state <= WAIT_HI;
                        count <= CW'(1);
                    end else begin
                        count <= '0;
                    end
                end
                WAIT_HI: begin
                    if (!s) begin
                        state <= LO;
                        count <= '0;
                    end else if (count == LAST) begin
                        state    <= HI;
                        count    <= '0;
                        sw_clean <= 1'b1;
                        sw_rise  <= 1'b1;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                HI: begin
                    if (!s) begin
                        state <= WAIT_LO;
                        count <= CW'(1);
                    end else begin
                        count <= '0;
                    end
                end
                WAIT_LO: begin
                    if (s) begin
                        state <= HI;
                        count <= '0;
                    end else if (count == LAST) begin
                        state    <= LO;
                        count    <= '0;
                        sw_clean <= 1'b0;
                        sw_fall  <= 1'b1;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                default: begin
                    state    <= LO;
                    count    <= '0;
                    sw_clean <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce: directed per-cycle vector table, then a long random bounce
// stream compared against a sliding-window reference model.
module tb_sw_debounce;
    import sw_debounce_pkg::*;

    localparam int N = DEFAULT_DEBOUNCE_CYCLES;
`ifdef SW_DEBOUNCE_SYNC_EN
    localparam int LAT = N + 2;
`else
    localparam int LAT = N;
`endif
    localparam int D = LAT - N;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic swRaw = 1'b0;
    logic swClean, swRise, swFall;

    int checks = 0;
    int errors = 0;

    sw_debounce #(.DEBOUNCE_CYCLES(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .sw_raw   (swRaw),
        .sw_clean (swClean),
        .sw_rise  (swRise),
        .sw_fall  (swFall)
    );

    always #5 clk = ~clk;

    // Reference: the clean level flips once the last N samples all disagree with it.
`ifdef SW_DEBOUNCE_SYNC_EN
    logic [1:0] mPipe = '0;
`endif
    logic [N-1:0] mHist = '0;
    logic mClean = 1'b0, mRise = 1'b0, mFall = 1'b0;

    always @(posedge clk) begin
        logic s;
        logic [N-1:0] h;
        if (reset) begin
`ifdef SW_DEBOUNCE_SYNC_EN
            mPipe <= '0;
`endif
            mHist  <= '0;
            mClean <= 1'b0;
            mRise  <= 1'b0;
            mFall  <= 1'b0;
        end else begin
`ifdef SW_DEBOUNCE_SYNC_EN
            s = mPipe[1];
            mPipe <= {mPipe[0], swRaw};
`else
            s = swRaw;
`endif
            h = {mHist[N-2:0], s};
            mHist <= h;
            mRise <= 1'b0;
            mFall <= 1'b0;
            if (!mClean && h == {N{1'b1}}) begin
                mClean <= 1'b1;
                mRise  <= 1'b1;
            end else if (mClean && h == {N{1'b0}}) begin
                mClean <= 1'b0;
                mFall  <= 1'b1;
            end
        end
    end

    typedef struct {
        logic rst;
        logic raw;
        logic clean;
        logic rise;
        logic fall;
    } vec_t;

    vec_t vecs[$];

    function automatic void addVec(logic rst, logic raw, logic c, logic r, logic f);
        vec_t v;
        v.rst = rst; v.raw = raw; v.clean = c; v.rise = r; v.fall = f;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic step(logic rst, logic raw);
        reset = rst;
        swRaw = raw;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset, then raw held high: one rise at LAT.
        addVec(1, 0, 0, 0, 0);
        addVec(1, 0, 0, 0, 0);
        for (int k = 1; k <= LAT + 2; k++) addVec(0, 1, k >= LAT, k == LAT, 0);
        // Three-cycle low glitch while high is rejected.
        for (int k = 1; k <= 3; k++) addVec(0, 0, 1, 0, 0);
        for (int k = 1; k <= LAT + 2; k++) addVec(0, 1, 1, 0, 0);
        // Clean fall.
        for (int k = 1; k <= LAT + 2; k++) addVec(0, 0, k < LAT, 0, k == LAT);
        // Three-cycle high pulse while low is rejected.
        for (int k = 1; k <= 3; k++) addVec(0, 1, 0, 0, 0);
        for (int k = 1; k <= LAT + 4; k++) addVec(0, 0, 0, 0, 0);
        // Back to high, then bounce 1-0-1-0-0-0-0...: single fall after 4 zero samples.
        for (int k = 1; k <= LAT + 2; k++) addVec(0, 1, k >= LAT, k == LAT, 0);
        for (int k = 1; k <= 11 + D; k++)
            addVec(0, (k == 1 || k == 3), k < 7 + D, 0, k == 7 + D);
        // Reset inside WAIT_HI with raw held high: abort, then debounce from scratch.
        for (int k = 1; k <= 3 + D; k++) addVec(0, 1, 0, 0, 0);
        addVec(1, 1, 0, 0, 0);
        addVec(1, 1, 0, 0, 0);
        for (int k = 1; k <= LAT + 2; k++) addVec(0, 1, k >= LAT, k == LAT, 0);
        // Reset inside WAIT_LO: abort with no fall pulse.
        for (int k = 1; k <= 3 + D; k++) addVec(0, 0, 1, 0, 0);
        addVec(1, 0, 0, 0, 0);
        addVec(1, 0, 0, 0, 0);
        for (int k = 1; k <= LAT + 2; k++) addVec(0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].raw);
            check($sformatf("vec%0d sw_clean", i), swClean, vecs[i].clean);
            check($sformatf("vec%0d sw_rise", i), swRise, vecs[i].rise);
            check($sformatf("vec%0d sw_fall", i), swFall, vecs[i].fall);
        end

        // Random bounce stream against the reference model.
        step(1, 0);
        begin
            logic lvl;
            int runLeft;
            lvl = 1'b0;
            runLeft = 0;
            for (int c = 0; c < 10000; c++) begin
                logic rst;
                if (runLeft == 0) begin
                    lvl = ~lvl;
                    runLeft = ($urandom_range(0, 3) == 0) ? $urandom_range(N, 2 * N + 2)
                                                          : $urandom_range(1, N);
                end
                runLeft--;
                rst = ($urandom_range(0, 499) == 0);
                step(rst, lvl);
                check($sformatf("rnd%0d sw_clean", c), swClean, mClean);
                check($sformatf("rnd%0d sw_rise", c), swRise, mRise);
                check($sformatf("rnd%0d sw_fall", c), swFall, mFall);
                check($sformatf("rnd%0d rise_fall_excl", c), swRise & swFall, 1'b0);
                check($sformatf("rnd%0d count_max", c), (int'(dut.count) <= N - 1), 1'b1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
